// File: rtl/gfx_pkg.sv
// Shared display-pipeline definitions: source scheduler states and defaults.
package gfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } gfx_state_e;

  localparam int unsigned GFX_SETTLE_CYCLES = 8;

endpackage

// File: rtl/gfx_settle_timer.sv
// Down-counter that times the quiet gap between a finished clear and ADC grant.
module gfx_settle_timer
  import gfx_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = GFX_SETTLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic last
);

  // A zero-cycle build still needs a legal one-bit counter; it is never loaded usefully.
  localparam int unsigned CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  logic [CW-1:0] count;

  // Load the settle length on entry, then count down while settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(SETTLE_CYCLES);
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign last = (count == CW'(1));

endmodule

// File: rtl/gfx_src_sched.sv
// Grants the output pixel stream to the clear generator after reset or on request,
// then to the ADC source once the clear has settled.
module gfx_src_sched
  import gfx_pkg::*;
#(
  parameter int unsigned FB_X_BITS     = 10,
  parameter int unsigned FB_Y_BITS     = 9,
  parameter int unsigned PIXEL_BITS    = 12,
  parameter int unsigned SETTLE_CYCLES = GFX_SETTLE_CYCLES
) (
  input  logic                  axi_clk,
  input  logic                  axi_resetn,
  input  logic                  clear_req,
  output logic                  clr_start,
  input  logic                  clr_tvalid,
  output logic                  clr_tready,
  input  logic                  clr_tlast,
  input  logic [FB_X_BITS-1:0]  clr_x,
  input  logic [FB_Y_BITS-1:0]  clr_y,
  input  logic [PIXEL_BITS-1:0] clr_color,
  input  logic                  adc_tvalid,
  output logic                  adc_tready,
  input  logic [FB_X_BITS-1:0]  adc_x,
  input  logic [FB_Y_BITS-1:0]  adc_y,
  input  logic [PIXEL_BITS-1:0] adc_color,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [FB_X_BITS-1:0]  m_x,
  output logic [FB_Y_BITS-1:0]  m_y,
  output logic [PIXEL_BITS-1:0] m_color,
  output logic                  adc_enable,
  output logic                  vga_enable,
  output logic                  busy
);

  gfx_state_e state, state_nxt;
  logic       pending;
  logic       entering_clear;
  logic       entering_settle;
  logic       entering_run;
  logic       settle_last;

  gfx_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk   (axi_clk),
    .rst_n (axi_resetn),
    .load  (entering_settle),
    .dec   (state == ST_SETTLE),
    .last  (settle_last)
  );

  // State register.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; RUN only leaves for a clear once no offered ADC beat is stalled.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   state_nxt = ST_CLEAR;
      ST_CLEAR:  if (clr_tvalid && m_tready && clr_tlast)
                   state_nxt = (SETTLE_CYCLES == 0) ? ST_RUN : ST_SETTLE;
      ST_SETTLE: if (settle_last) state_nxt = ST_RUN;
      ST_RUN:    if (pending && (!adc_tvalid || m_tready)) state_nxt = ST_CLEAR;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign entering_clear  = (state_nxt == ST_CLEAR)  && (state != ST_CLEAR);
  assign entering_settle = (state_nxt == ST_SETTLE) && (state != ST_SETTLE);
  assign entering_run    = (state_nxt == ST_RUN)    && (state != ST_RUN);

  // Sticky clear request; a request coinciding with a CLEAR entry is absorbed by it.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      pending <= 1'b0;
    end else begin
      pending <= (pending || clear_req) && !entering_clear;
    end
  end

  // Registered status flags derived from the upcoming state.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      clr_start  <= 1'b0;
      adc_enable <= 1'b0;
      vga_enable <= 1'b0;
    end else begin
      clr_start  <= entering_clear;
      adc_enable <= (state_nxt == ST_RUN);
      if (entering_run) vga_enable <= 1'b1;
    end
  end

  assign busy = (state != ST_RUN);

  // Zero-latency source mux keyed on the registered state; the idle source sees ready low.
  always_comb begin
    m_tvalid   = 1'b0;
    m_x        = '0;
    m_y        = '0;
    m_color    = '0;
    clr_tready = 1'b0;
    adc_tready = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        m_tvalid   = clr_tvalid;
        m_x        = clr_x;
        m_y        = clr_y;
        m_color    = clr_color;
        clr_tready = m_tready;
      end
      ST_RUN: begin
        m_tvalid   = adc_tvalid;
        m_x        = adc_x;
        m_y        = adc_y;
        m_color    = adc_color;
        adc_tready = m_tready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gfx_src_sched.sv
// Directed bench for the clear/ADC source scheduler, default and zero-settle builds.
module tb_gfx_src_sched;

  logic        clk;
  logic        rst_n;
  logic        clear_req;
  logic        clr_tvalid, clr_tlast;
  logic [9:0]  clr_x, adc_x;
  logic [8:0]  clr_y, adc_y;
  logic [11:0] clr_color, adc_color;
  logic        adc_tvalid;
  logic        m_tready;

  logic        clr_start, clr_tready, adc_tready, m_tvalid;
  logic [9:0]  m_x;
  logic [8:0]  m_y;
  logic [11:0] m_color;
  logic        adc_enable, vga_enable, busy;

  logic        z_clr_start, z_clr_tready, z_adc_tready, z_m_tvalid;
  logic [9:0]  z_m_x;
  logic [8:0]  z_m_y;
  logic [11:0] z_m_color;
  logic        z_adc_enable, z_vga_enable, z_busy;

  int total;
  int bad;

  gfx_src_sched dut (
    .axi_clk    (clk),        .axi_resetn (rst_n),      .clear_req  (clear_req),
    .clr_start  (clr_start),  .clr_tvalid (clr_tvalid), .clr_tready (clr_tready),
    .clr_tlast  (clr_tlast),  .clr_x      (clr_x),      .clr_y      (clr_y),
    .clr_color  (clr_color),  .adc_tvalid (adc_tvalid), .adc_tready (adc_tready),
    .adc_x      (adc_x),      .adc_y      (adc_y),      .adc_color  (adc_color),
    .m_tvalid   (m_tvalid),   .m_tready   (m_tready),   .m_x        (m_x),
    .m_y        (m_y),        .m_color    (m_color),    .adc_enable (adc_enable),
    .vga_enable (vga_enable), .busy       (busy)
  );

  gfx_src_sched #(.SETTLE_CYCLES(0)) dut0 (
    .axi_clk    (clk),          .axi_resetn (rst_n),        .clear_req  (clear_req),
    .clr_start  (z_clr_start),  .clr_tvalid (clr_tvalid),   .clr_tready (z_clr_tready),
    .clr_tlast  (clr_tlast),    .clr_x      (clr_x),        .clr_y      (clr_y),
    .clr_color  (clr_color),    .adc_tvalid (adc_tvalid),   .adc_tready (z_adc_tready),
    .adc_x      (adc_x),        .adc_y      (adc_y),        .adc_color  (adc_color),
    .m_tvalid   (z_m_tvalid),   .m_tready   (m_tready),     .m_x        (z_m_x),
    .m_y        (z_m_y),        .m_color    (z_m_color),    .adc_enable (z_adc_enable),
    .vga_enable (z_vga_enable), .busy       (z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_req = 1'b0;
    clr_tvalid = 1'b0; clr_tlast = 1'b0;
    clr_x = '0; clr_y = '0; clr_color = '0;
    adc_tvalid = 1'b0;
    adc_x = 10'h3ff; adc_y = 9'h1aa; adc_color = 12'hf0f;
    m_tready = 1'b1;

    // Reset values
    #3;
    chk("rst_busy", busy, 1);
    chk("rst_clr_start", clr_start, 0);
    chk("rst_adc_en", adc_enable, 0);
    chk("rst_vga_en", vga_enable, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_clr_tready", clr_tready, 0);
    chk("rst_adc_tready", adc_tready, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_busy", busy, 1);
    chk("idle_clr_start", clr_start, 0);

    // Cycle 1: CLEAR, first beat; ADC offered but must not be granted
    nxt();
    chk("c1_clr_start", clr_start, 1);
    clr_tvalid = 1'b1; clr_x = 10'd1; clr_y = 9'd1; clr_color = 12'h001;
    adc_tvalid = 1'b1;
    #1;
    chk("c1_m_tvalid", m_tvalid, 1);
    chk("c1_m_x", m_x, 10'd1);
    chk("c1_m_color", m_color, 12'h001);
    chk("c1_clr_tready", clr_tready, 1);
    chk("c1_adc_tready", adc_tready, 0);

    // Cycle 2: second beat accepted
    nxt();
    chk("c2_clr_start", clr_start, 0);
    clr_x = 10'd2; clr_y = 9'd2; clr_color = 12'h002;
    #1;
    chk("c2_m_x", m_x, 10'd2);
    chk("c2_clr_tready", clr_tready, 1);

    // Cycles 3-4: last beat stalled by backpressure
    nxt();
    clr_x = 10'd3; clr_y = 9'd3; clr_color = 12'h003; clr_tlast = 1'b1;
    m_tready = 1'b0;
    #1;
    chk("c3_m_x", m_x, 10'd3);
    chk("c3_clr_tready", clr_tready, 0);
    chk("c3_m_tvalid", m_tvalid, 1);
    nxt();
    #1;
    chk("c4_m_tvalid_held", m_tvalid, 1);
    chk("c4_m_x_held", m_x, 10'd3);
    chk("c4_m_y_held", m_y, 9'd3);
    chk("c4_busy", busy, 1);

    // Cycle 5: last beat accepted (N = 5)
    nxt();
    m_tready = 1'b1;
    #1;
    chk("c5_clr_tready", clr_tready, 1);
    chk("c5_z_busy", z_busy, 1);

    // Cycles 6-13: SETTLE; zero-settle build already in RUN at cycle 6
    nxt();
    chk("c6_z_busy", z_busy, 0);
    chk("c6_z_adc_en", z_adc_enable, 1);
    chk("c6_z_vga_en", z_vga_enable, 1);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("settle_m_tvalid", m_tvalid, 0);
      chk("settle_clr_tready", clr_tready, 0);
      chk("settle_adc_tready", adc_tready, 0);
      chk("settle_busy", busy, 1);
      chk("settle_adc_en", adc_enable, 0);
      chk("settle_vga_en", vga_enable, 0);
      nxt();
    end

    // Cycle 14: RUN; clear requested while an ADC beat is stalled
    clr_tvalid = 1'b0; clr_tlast = 1'b0;
    chk("c14_adc_en", adc_enable, 1);
    chk("c14_vga_en", vga_enable, 1);
    chk("c14_busy", busy, 0);
    adc_tvalid = 1'b1; adc_x = 10'h111; adc_y = 9'h022; adc_color = 12'h333;
    m_tready = 1'b0;
    clear_req = 1'b1;
    #1;
    chk("c14_m_tvalid", m_tvalid, 1);
    chk("c14_m_x", m_x, 10'h111);
    chk("c14_adc_tready", adc_tready, 0);
    chk("c14_clr_tready", clr_tready, 0);
    nxt();
    clear_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_busy", busy, 0);
      chk("stall_m_tvalid", m_tvalid, 1);
      chk("stall_m_x", m_x, 10'h111);
      chk("stall_m_color", m_color, 12'h333);
      chk("stall_clr_start", clr_start, 0);
      nxt();
    end
    m_tready = 1'b1;
    #1;
    chk("c19_busy", busy, 0);
    chk("c19_adc_tready", adc_tready, 1);

    // Cycle 20: CLEAR entered after the stalled beat transferred
    nxt();
    chk("c20_busy", busy, 1);
    chk("c20_clr_start", clr_start, 1);
    chk("c20_adc_en", adc_enable, 0);
    chk("c20_vga_en", vga_enable, 1);
    adc_tvalid = 1'b0;
    clr_tvalid = 1'b1; clr_tlast = 1'b1; clr_x = 10'd9; clr_y = 9'd9; clr_color = 12'h009;
    #1;
    chk("c20_adc_tready", adc_tready, 0);
    chk("c20_m_x", m_x, 10'd9);

    // Cycles 21-28: SETTLE with a clear request arriving midway
    nxt();
    chk("c21_clr_start", clr_start, 0);
    clr_tvalid = 1'b0; clr_tlast = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clear_req = (i == 2);
      #1;
      chk("settle2_vga_en", vga_enable, 1);
      chk("settle2_busy", busy, 1);
      chk("settle2_m_tvalid", m_tvalid, 0);
      nxt();
    end

    // Cycle 29: one RUN cycle; a request here coincides with the CLEAR entry
    clear_req = 1'b1;
    #1;
    chk("c29_busy", busy, 0);
    chk("c29_adc_en", adc_enable, 1);
    chk("c29_vga_en", vga_enable, 1);
    nxt();
    clear_req = 1'b0;
    chk("c30_busy", busy, 1);
    chk("c30_clr_start", clr_start, 1);
    chk("c30_vga_en", vga_enable, 1);
    clr_tvalid = 1'b1; clr_tlast = 1'b1;
    nxt();
    clr_tvalid = 1'b0; clr_tlast = 1'b0;
    repeat (8) nxt();
    chk("c39_busy", busy, 0);
    nxt();
    chk("c40_busy_no_reclear", busy, 0);
    chk("c40_clr_start", clr_start, 0);

    // Reset pulsed mid-RUN
    adc_tvalid = 1'b1;
    #1;
    chk("prerst_m_tvalid", m_tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 1);
    chk("mrst_adc_en", adc_enable, 0);
    chk("mrst_vga_en", vga_enable, 0);
    chk("mrst_m_tvalid", m_tvalid, 0);
    chk("mrst_adc_tready", adc_tready, 0);
    chk("mrst_z_vga_en", z_vga_enable, 0);
    chk("mrst_z_busy", z_busy, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_clr_start", clr_start, 0);
    chk("rel_busy", busy, 1);
    nxt();
    chk("restart_clr_start", clr_start, 1);
    chk("restart_busy", busy, 1);
    chk("restart_adc_en", adc_enable, 0);
    nxt();
    chk("restart_clr_start_drop", clr_start, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gfx_src_sched.md
GFX_SRC_SCHED -- requirements
Module: gfx_src_sched

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- FB_X_BITS, 10, framebuffer x coordinate width
- FB_Y_BITS, 9, framebuffer y coordinate width
- PIXEL_BITS, 12, color width
- SETTLE_CYCLES, 8, idle cycles after the final clear beat before ADC is granted
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- axi_clk  in  1  sole clock
- axi_resetn  in  1  asynchronous, active-low reset
- clear_req  in  1  pulse requesting a full-screen clear
- clr_start  out  1  one-cycle pulse starting the clear generator
- clr_tvalid / clr_tready / clr_tlast  in/out/in  1 each  clear source handshake and last beat
- clr_x / clr_y / clr_color  in  FB_X_BITS / FB_Y_BITS / PIXEL_BITS  clear pixel
- adc_tvalid / adc_tready  in/out  1 each  ADC source handshake
- adc_x / adc_y / adc_color  in  FB_X_BITS / FB_Y_BITS / PIXEL_BITS  ADC pixel
- m_tvalid / m_tready  out/in  1 each  output pixel stream handshake
- m_x / m_y / m_color  out  FB_X_BITS / FB_Y_BITS / PIXEL_BITS  granted pixel
- adc_enable  out  1  high in RUN only
- vga_enable  out  1  sticky; set when the first clear has settled
- busy  out  1  high in any state other than RUN

Function
REQ-003 The FSM SHALL have four states: IDLE, CLEAR, SETTLE and RUN.
REQ-004 IDLE SHALL last exactly one cycle after reset release, then go to CLEAR.
REQ-005 clr_start SHALL pulse for exactly one cycle on every entry to CLEAR.
REQ-006 In CLEAR:
- m_* SHALL carry clr_*
- clr_tready SHALL equal m_tready
- adc_tready SHALL be 0
REQ-007 CLEAR SHALL go to SETTLE on the cycle where clr_tvalid, m_tready and clr_tlast are all 1.
REQ-008 If SETTLE_CYCLES is 0, CLEAR SHALL go directly to RUN on that same cycle.
REQ-009 In SETTLE:
- m_tvalid SHALL be 0
- clr_tready and adc_tready SHALL both be 0
- a down-counter of width $clog2(SETTLE_CYCLES+1) SHALL load SETTLE_CYCLES on entry
- exit to RUN SHALL occur when the counter reaches 1 and decrements (exactly SETTLE_CYCLES cycles in SETTLE)
REQ-010 In RUN:
- m_* SHALL carry adc_*
- adc_tready SHALL equal m_tready
- clr_tready SHALL be 0
REQ-011 The output mux SHALL be combinational on the registered state (zero-cycle latency source to m_*); non-granted ready SHALL be 0.
REQ-012 clear_req SHALL set a sticky pending flag in any state; the flag SHALL clear on entry to CLEAR.
REQ-013 RUN SHALL go to CLEAR when pending is set and (adc_tvalid is 0 or m_tready is 1), so an offered beat is never withdrawn.
REQ-014 adc_enable SHALL drop in the cycle RUN exits.
REQ-015 clear_req arriving in the same cycle as a CLEAR entry SHALL be consumed by that entry, not re-latched.
REQ-016 clear_req during CLEAR or SETTLE SHALL cause a second clear immediately after reaching RUN (one RUN cycle minimum).
REQ-017 vga_enable SHALL set on the first SETTLE-to-RUN transition and never clear except by reset.
REQ-018 While m_tvalid is 1 and m_tready is 0, m_* SHALL stay stable, provided the granted source obeys the AXI-stream hold rule.

Reset
REQ-019 On axi_resetn low, asynchronously:
- state SHALL be IDLE
- counter and pending SHALL be 0
- clr_start, adc_enable and vga_enable SHALL be 0
- busy SHALL be 1
- m_tvalid, clr_tready and adc_tready SHALL be 0
REQ-020 Reset asserted mid-CLEAR or mid-RUN SHALL abandon the operation; after release the sequence SHALL restart from IDLE with a fresh clr_start.

Structure
REQ-021 The state enum and the SETTLE_CYCLES default SHALL live in the shared gfx package, for reuse by other display top levels.
REQ-022 The settle counter MAY be a sub-module named gfx_settle_timer; everything else SHALL be flat.

Verification
REQ-023 Reset release with m_tready=1: clr_start pulses at cycle 1 after release; clr_tlast accepted at cycle N; m_tvalid=0 for cycles N+1..N+8; adc_enable=1 and vga_enable=1 from cycle N+9.
REQ-024 Backpressure in CLEAR: m_tready toggles 1,0,0,1. The m_* beat is held unchanged while stalled, and exactly one beat is consumed per m_tready=1 cycle.
REQ-025 clear_req in RUN while adc_tvalid=1 and m_tready=0 for 5 cycles: RUN is held and the beat is stable. CLEAR is entered the cycle after m_tready=1, and clr_start pulses once.
REQ-026 clear_req during SETTLE: RUN is entered, then CLEAR follows next cycle; vga_enable stays 1 throughout.
REQ-027 axi_resetn pulsed low mid-RUN: all outputs return to reset values immediately, and the startup sequence repeats.
REQ-028 SETTLE_CYCLES=0 build: the CLEAR-to-RUN transition happens on the clr_tlast handshake cycle, with no SETTLE cycle.
